// File: rtl/fetch_redirect.sv
// fetch_redirect: fetch-side PC generator and instruction-ROM requester.
//
// Owns the PC and issues one ROM request per PC. It holds the fetched word in
// IF_ID_bus until decode accepts it with next_fetch. An exception redirect
// from write-back overrides everything else in the same cycle. A misaligned
// PC is not sent to the ROM; it is passed to decode tagged with fetch_error.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   IF_valid      fetch enabled by pipeline control
//   next_fetch    decode accepts IF_ID_bus; advance the PC
//   jbr_bus       {jbr_taken, jbr_target[31:0]} from decode
//   exc_bus       {exc_valid, exc_pc[31:0]} from write-back
//   inst_req      ROM read strobe (combinational)
//   inst_addr     ROM read address (= pc)
//   inst          ROM read data, valid the cycle after inst_req
//   IF_over       IF_ID_bus holds a valid instruction (combinational)
//   IF_ID_bus     {fetch_error, pc[31:0], inst[31:0]}
//   IF_pc         current PC
//
// Optional feature, enabled by defining FETCH_REDIRECT_CNT_EN:
//   redirect_cnt  counts cycles that have exc_valid or an accepted jbr_taken
//   drop_cnt      counts ROM responses dropped by a redirect during WAIT
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_valid,
  input  logic        next_fetch,
  input  logic [32:0] jbr_bus,
  input  logic [32:0] exc_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic        IF_over,
  output logic [64:0] IF_ID_bus,
  output logic [31:0] IF_pc
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BUS_W = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [BUS_W-1:0]   bus_q, bus_d;

  logic               jbr_taken;
  logic [XLEN-1:0]    jbr_target;
  logic               exc_valid;
  logic [XLEN-1:0]    exc_pc;
  logic               pc_aligned;

  assign jbr_taken  = jbr_bus[32];
  assign jbr_target = jbr_bus[31:0];
  assign exc_valid  = exc_bus[32];
  assign exc_pc     = exc_bus[31:0];
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  assign inst_addr  = pc_q;
  assign IF_pc      = pc_q;
  assign IF_ID_bus  = bus_q;

  // State, PC and fetch-bus registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bus_q   <= bus_d;
    end
  end

  // Next-state, next-PC and strobe logic; a redirect overrides everything
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bus_d    = bus_q;
    inst_req = 1'b0;
    IF_over  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (IF_valid) begin
          if (pc_aligned) begin
            // resetn gate keeps the strobe low while reset is asserted
            inst_req = resetn;
            state_d  = WAIT;
          end else begin
            bus_d   = {1'b1, pc_q, XLEN'(0)};
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        bus_d   = {1'b0, pc_q, inst};
        state_d = HOLD;
      end
      HOLD: begin
        IF_over = 1'b1;
        if (next_fetch) begin
          pc_d    = jbr_taken ? jbr_target : pc_q + PC_STEP;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect drops any in-flight response and clears the error tag
    if (exc_valid) begin
      state_d  = IDLE;
      pc_d     = exc_pc;
      bus_d    = {1'b0, bus_q[BUS_W-2:0]};
      inst_req = 1'b0;
      IF_over  = 1'b0;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic jbr_accept;
  assign jbr_accept = (state_q == HOLD) && next_fetch && jbr_taken;

  // Redirect and dropped-response counters, wrapping at 2^32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (exc_valid || jbr_accept) redirect_cnt <= redirect_cnt + 32'd1;
      if (exc_valid && (state_q == WAIT)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect: directed-vector bench for fetch_redirect.
// A small ROM model returns a fixed word for 0xBFC00000 and {addr[15:0],16'h1234}
// for any other address, one cycle after the request.
module tb_fetch_redirect;

  logic        clk;
  logic        resetn;
  logic        IF_valid;
  logic        next_fetch;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        IF_over;
  logic [64:0] IF_ID_bus;
  logic [31:0] IF_pc;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_redirect dut (
    .clk        (clk),
    .resetn     (resetn),
    .IF_valid   (IF_valid),
    .next_fetch (next_fetch),
    .jbr_bus    (jbr_bus),
    .exc_bus    (exc_bus),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .IF_over    (IF_over),
    .IF_ID_bus  (IF_ID_bus),
    .IF_pc      (IF_pc)
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr == 32'hBFC00000) return 32'h24010001;
    return {addr[15:0], 16'h1234};
  endfunction

  // ROM: data valid the cycle after the request
  always @(posedge clk) begin
    if (inst_req) inst <= rom_word(inst_addr);
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    inst       = 32'h0;
    resetn     = 1'b0;
    IF_valid   = 1'b0;
    next_fetch = 1'b0;
    jbr_bus    = '0;
    exc_bus    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",  65'(inst_req),  65'(0));
    check("rst_over", 65'(IF_over),   65'(0));
    check("rst_bus",  IF_ID_bus,      65'(0));
    check("rst_pc",   65'(IF_pc),     65'(32'hBFC00000));
`ifdef FETCH_REDIRECT_CNT_EN
    check("rst_rcnt", 65'(redirect_cnt), 65'(0));
    check("rst_dcnt", 65'(drop_cnt),     65'(0));
`endif

    // Released but IF_valid low: no request, PC unchanged
    @(negedge clk); resetn = 1'b1; #1;
    check("idle_noreq", 65'(inst_req), 65'(0));
    @(negedge clk); #1;
    check("idle_pc",    65'(IF_pc),    65'(32'hBFC00000));

    // First fetch: request at cycle 0, IF_over at cycle 2
    IF_valid = 1'b1; #1;
    check("f0_req",  65'(inst_req),  65'(1));
    check("f0_addr", 65'(inst_addr), 65'(32'hBFC00000));
    @(negedge clk); #1;
    check("f0_wait_req",  65'(inst_req), 65'(0));
    check("f0_wait_over", 65'(IF_over),  65'(0));
    @(negedge clk); #1;
    check("f0_over", 65'(IF_over), 65'(1));
    check("f0_bus",  IF_ID_bus, {1'b0, 32'hBFC00000, 32'h24010001});
    @(negedge clk); #1;
    check("f0_hold_bus", IF_ID_bus, {1'b0, 32'hBFC00000, 32'h24010001});

    // Taken jump
    next_fetch = 1'b1; jbr_bus = {1'b1, 32'hBFC00100};
    @(negedge clk); next_fetch = 1'b0; jbr_bus = '0; #1;
    check("jbr_req",  65'(inst_req),  65'(1));
    check("jbr_addr", 65'(inst_addr), 65'(32'hBFC00100));
    // next_fetch and jump in WAIT must be ignored
    @(negedge clk); next_fetch = 1'b1; jbr_bus = {1'b1, 32'hDEAD0000}; #1;
    check("wait_over", 65'(IF_over), 65'(0));
    @(negedge clk); next_fetch = 1'b0; jbr_bus = '0; #1;
    check("jbr_bus", IF_ID_bus, {1'b0, 32'hBFC00100, 32'h01001234});
    check("wait_nf_pc", 65'(IF_pc), 65'(32'hBFC00100));

    // Sequential advance
    next_fetch = 1'b1;
    @(negedge clk); next_fetch = 1'b0; #1;
    check("seq_addr", 65'(inst_addr), 65'(32'hBFC00104));
    check("seq_req",  65'(inst_req),  65'(1));

    // Redirect during WAIT drops the response
    @(negedge clk); exc_bus = {1'b1, 32'hBFC00380}; #1;
    check("excw_over", 65'(IF_over),  65'(0));
    check("excw_req",  65'(inst_req), 65'(0));
    @(negedge clk); exc_bus = '0; #1;
    check("excw_addr", 65'(inst_addr), 65'(32'hBFC00380));
    check("excw_req2", 65'(inst_req),  65'(1));
    check("excw_bus",  IF_ID_bus, {1'b0, 32'hBFC00100, 32'h01001234});
`ifdef FETCH_REDIRECT_CNT_EN
    check("excw_dcnt", 65'(drop_cnt),     65'(1));
    check("excw_rcnt", 65'(redirect_cnt), 65'(2));
`endif
    @(negedge clk);
    @(negedge clk); #1;
    check("excw_newbus", IF_ID_bus, {1'b0, 32'hBFC00380, 32'h03801234});

    // Redirect beats next_fetch+jump in HOLD; target is misaligned
    next_fetch = 1'b1; jbr_bus = {1'b1, 32'hBFC00500}; exc_bus = {1'b1, 32'hBFC00402}; #1;
    check("prio_over", 65'(IF_over), 65'(0));
    @(negedge clk); next_fetch = 1'b0; jbr_bus = '0; exc_bus = '0; #1;
    check("prio_pc",   65'(IF_pc),    65'(32'hBFC00402));
    check("mis_noreq", 65'(inst_req), 65'(0));
    @(negedge clk); #1;
    check("mis_bus",  IF_ID_bus, {1'b1, 32'hBFC00402, 32'h0});
    check("mis_over", 65'(IF_over), 65'(1));

    // Redirect held for three cycles: no request until it falls
    exc_bus = {1'b1, 32'hBFC00600};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_exc_req",  65'(inst_req), 65'(0));
      check("hold_exc_over", 65'(IF_over),  65'(0));
      @(negedge clk);
    end
    exc_bus = '0; #1;
    check("hold_exc_addr", 65'(inst_addr), 65'(32'hBFC00600));
    check("hold_exc_req1", 65'(inst_req),  65'(1));
    @(negedge clk);
    @(negedge clk); #1;
    check("hold_exc_bus", IF_ID_bus, {1'b0, 32'hBFC00600, 32'h06001234});

    // PC wraparound
    exc_bus = {1'b1, 32'hFFFFFFFC};
    @(negedge clk); exc_bus = '0; #1;
    check("top_addr", 65'(inst_addr), 65'(32'hFFFFFFFC));
    @(negedge clk);
    @(negedge clk); #1;
    check("top_bus", IF_ID_bus, {1'b0, 32'hFFFFFFFC, 32'hFFFC1234});
`ifdef FETCH_REDIRECT_CNT_EN
    check("end_rcnt", 65'(redirect_cnt), 65'(7));
    check("end_dcnt", 65'(drop_cnt),     65'(1));
`endif
    next_fetch = 1'b1;
    @(negedge clk); next_fetch = 1'b0; #1;
    check("wrap_addr", 65'(inst_addr), 65'(32'h0));
    check("wrap_req",  65'(inst_req),  65'(1));

    // Reset asserted mid-WAIT
    @(negedge clk); resetn = 1'b0; #1;
    check("rw_over", 65'(IF_over),  65'(0));
    check("rw_bus",  IF_ID_bus,     65'(0));
    check("rw_pc",   65'(IF_pc),    65'(32'hBFC00000));
    check("rw_req",  65'(inst_req), 65'(0));
`ifdef FETCH_REDIRECT_CNT_EN
    check("rw_rcnt", 65'(redirect_cnt), 65'(0));
`endif
    @(negedge clk); resetn = 1'b1; #1;
    check("rw_req2", 65'(inst_req), 65'(1));
    @(negedge clk);
    @(negedge clk); #1;
    check("rw_newbus", IF_ID_bus, {1'b0, 32'hBFC00000, 32'h24010001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
